pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_W, default 16, program counter width in bits (4..32).
REQ-002 Parameter RESET_VEC, default 16'h0000, value loaded into pc_o on reset.
REQ-003 Parameter INC, default 1, sequential increment added to pc_o each advancing cycle.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, 2..16.
REQ-005 Port clk  input  1  system clock; all state updates on rising edge.
REQ-006 Port rst_n  input  1  reset; synchronous, active-low.
REQ-007 Port stall  input  1  hold all state this cycle.
REQ-008 Port br_taken  input  1  conditional branch resolved taken.
REQ-009 Port br_target  input  PC_W  branch destination.
REQ-010 Port jmp  input  1  unconditional jump.
REQ-011 Port call  input  1  jump and push return address.
REQ-012 Port jmp_target  input  PC_W  destination for jmp and call.
REQ-013 Port ret  input  1  pop return address and jump to it.
REQ-014 Port pc_o  output  PC_W  registered current program counter.
REQ-015 Port pc_next_o  output  PC_W  combinational value pc_o takes at next edge.
REQ-016 Port valid_o  output  1  pc_o holds a fetchable address.
REQ-017 Port ras_empty / ras_full  output  1 each  stack occupancy flags, combinational from count.
REQ-018 Port ras_ovf / ras_unf  output  1 each  sticky overflow / underflow error flags.

Function
REQ-019 pc_o SHALL update only on the rising edge of clk, with one-cycle latency from control inputs to pc_o.
REQ-020 Next-PC selection priority SHALL be: stall > ret > call > jmp > br_taken > sequential (pc_o + INC).
REQ-021 stall=1 SHALL hold pc_o, stack contents, count and flags; all other control inputs ignored that cycle.
REQ-022 ret with stack non-empty SHALL load top entry into pc_o and decrement count.
REQ-023 ret with stack empty SHALL advance sequentially, leave count at 0, and set ras_unf.
REQ-024 call SHALL load jmp_target and push (pc_o + INC) mod 2^PC_W.
REQ-025 call with stack full SHALL overwrite the oldest entry (circular), keep count = RAS_DEPTH, and set ras_ovf.
REQ-026 jmp SHALL load jmp_target; br_taken SHALL load br_target; neither touches the stack.
REQ-027 Sequential increment SHALL wrap modulo 2^PC_W (all-ones + 1 -> 0), no flag.
REQ-028 call and ret asserted together SHALL perform ret only; no push.
REQ-029 pc_next_o SHALL equal the value selected by REQ-020 in the current cycle, including pc_o when stall=1.
REQ-030 ras_empty SHALL be 1 iff count = 0; ras_full SHALL be 1 iff count = RAS_DEPTH.
REQ-031 ras_ovf and ras_unf SHALL remain set until reset.

Reset
REQ-032 On a clock edge with rst_n=0: pc_o = RESET_VEC, count = 0, ras_ovf = 0, ras_unf = 0, valid_o = 0, regardless of stall or any control input.
REQ-033 valid_o SHALL become 1 on the first edge with rst_n=1 and stay 1 until the next reset.
REQ-034 On the first edge after reset release, pc_o SHALL follow REQ-020 from RESET_VEC (sequential: RESET_VEC + INC).
REQ-035 Reset asserted mid-sequence SHALL discard all stack entries; a ret after reset underflows.
REQ-036 Stack entry storage need not be cleared on reset; only count and pointers are cleared.

Verification
REQ-037 Reset then 3 idle cycles (PC_W=16, INC=1) -> pc_o 0x0000, 0x0001, 0x0002, 0x0003; valid_o 0 during reset, 1 after.
REQ-038 pc_o=0x0010, call jmp_target=0x0200 -> pc_o=0x0200; two idle cycles -> 0x0202; ret -> pc_o=0x0011, ras_empty=1.
REQ-039 Five nested calls, RAS_DEPTH=4 -> ras_full=1, ras_ovf=1 after 5th; four rets return the 4 newest addresses in LIFO order; 5th ret -> sequential, ras_unf=1.
REQ-040 pc_o=0x0040, stall=1 with br_taken=1 br_target=0x0100 -> pc_o stays 0x0040, pc_next_o=0x0040; stall released with br_taken=1 -> pc_o=0x0100.
REQ-041 pc_o=0xFFFF idle -> pc_o=0x0000; same cycle jmp=1 and br_taken=1 -> jmp_target wins.
REQ-042 Two calls pushed, rst_n=0 one cycle with call=1 -> pc_o=RESET_VEC, ras_empty=1, flags 0; next ret -> ras_unf=1.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/call/return selection and a
// circular return-address stack. pc_o is registered; pc_next_o is the value
// pc_o will take at the next rising edge. The stack overwrites its oldest
// entry when a call arrives while full, and both error flags are sticky
// until reset.
module pc_unit #(
  parameter int unsigned     PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int unsigned     INC       = 1,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp,
  input  logic            call,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            ret,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_next_o,
  output logic            valid_o,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

  localparam int unsigned     PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W = PTR_W + 1;
  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;
  // wr_ptr_q is the slot the next push writes; the top of stack is one below.
  logic [PTR_W-1:0] wr_ptr_q;
  logic             ovf_q;
  logic             unf_q;
  logic [PC_W-1:0]  ras_mem_q [RAS_DEPTH];

  logic [PC_W-1:0]  seq_pc;
  logic [PC_W-1:0]  top_addr;
  logic [PC_W-1:0]  pc_d;
  logic             empty;
  logic             full;
  logic             do_push;

  // Next-PC selection: stall > ret > call > jmp > br_taken > sequential.
  always_comb begin
    seq_pc   = pc_q + INC_V;
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_V);
    top_addr = ras_mem_q[wr_ptr_q - PTR_W'(1)];
    do_push  = call && !ret;
    pc_d     = seq_pc;
    if (stall) begin
      pc_d = pc_q;
    end else if (ret) begin
      pc_d = empty ? seq_pc : top_addr;
    end else if (call || jmp) begin
      pc_d = jmp_target;
    end else if (br_taken) begin
      pc_d = br_target;
    end
  end

  // Stack entry storage; never cleared, only count/pointer are reset.
  always_ff @(posedge clk) begin
    if (rst_n && !stall && do_push) begin
      ras_mem_q[wr_ptr_q] <= seq_pc;
    end
  end

  // PC, occupancy, pointer and sticky flags; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_VEC;
      valid_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      if (!stall) begin
        pc_q <= pc_d;
        if (ret) begin
          if (empty) begin
            unf_q <= 1'b1;
          end else begin
            wr_ptr_q <= wr_ptr_q - PTR_W'(1);
            count_q  <= count_q - CNT_W'(1);
          end
        end else if (call) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          if (full) begin
            ovf_q <= 1'b1;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;
  assign valid_o   = valid_q;
  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios with literal expectations plus randomized
// stimulus, all checked every cycle against a queue-based reference model.
module tb_pc_unit;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, jmp, call, ret;
  logic [15:0] br_target, jmp_target;
  logic [15:0] pc_o, pc_next_o;
  logic        valid_o, ras_empty, ras_full, ras_ovf, ras_unf;

  always #5 clk = ~clk;

  pc_unit #(.PC_W(16), .RESET_VEC(16'h0000), .INC(1), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jmp(jmp), .call(call), .jmp_target(jmp_target),
    .ret(ret), .pc_o(pc_o), .pc_next_o(pc_next_o), .valid_o(valid_o),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Stack as a queue: back is the newest entry, front the oldest.
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_valid, m_ovf, m_unf;
  bit          m_known = 0;

  function automatic logic [15:0] m_next();
    if (stall)    return m_pc;
    if (ret)      return (m_stk.size() == 0) ? m_pc + 16'd1 : m_stk[m_stk.size()-1];
    if (call)     return jmp_target;
    if (jmp)      return jmp_target;
    if (br_taken) return br_target;
    return m_pc + 16'd1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 16'h0000; m_stk.delete(); m_ovf = 0; m_unf = 0; m_valid = 0;
      m_known = 1;
    end else if (m_known) begin
      logic [15:0] nxt;
      m_valid = 1;
      if (!stall) begin
        nxt = m_next();
        if (ret) begin
          if (m_stk.size() == 0) m_unf = 1;
          else void'(m_stk.pop_back());
        end else if (call) begin
          m_stk.push_back(m_pc + 16'd1);
          if (m_stk.size() > DEPTH) begin
            void'(m_stk.pop_front());
            m_ovf = 1;
          end
        end
        m_pc = nxt;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_known) begin
      chk("pc_o", pc_o, m_pc);
      chk("pc_next_o", pc_next_o, m_next());
      chk("valid_o", valid_o, m_valid);
      chk("ras_empty", ras_empty, m_stk.size() == 0);
      chk("ras_full", ras_full, m_stk.size() == DEPTH);
      chk("ras_ovf", ras_ovf, m_ovf);
      chk("ras_unf", ras_unf, m_unf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic r, input logic s, input logic b, input logic [15:0] bt,
                        input logic j, input logic c, input logic [15:0] jt, input logic rt);
    rst_n = r; stall = s; br_taken = b; br_target = bt;
    jmp = j; call = c; jmp_target = jt; ret = rt;
  endtask

  // Advance one edge; returns #1 after it so outputs reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1, 0, 0, 16'h0, 0, 0, 16'h0, 0);
    tick();
  endtask

  task automatic do_jmp(input logic [15:0] t);
    set_in(1, 0, 0, 16'h0, 1, 0, t, 0);
    tick();
  endtask

  task automatic do_call(input logic [15:0] t);
    set_in(1, 0, 0, 16'h0, 0, 1, t, 0);
    tick();
  endtask

  task automatic do_ret();
    set_in(1, 0, 0, 16'h0, 0, 0, 16'h0, 1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_in(0, 0, 0, 16'h0, 0, 0, 16'h0, 0);

    // Reset then three idle cycles
    tick(); tick();
    chk("rst_pc", pc_o, 16'h0000);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_empty", ras_empty, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      idle();
      chk("seq_pc", pc_o, 16'(i));
      chk("seq_valid", valid_o, 1'b1);
    end

    // Call / return round trip
    do_jmp(16'h0010);
    chk("jmp_pc", pc_o, 16'h0010);
    do_call(16'h0200);
    chk("call_pc", pc_o, 16'h0200);
    chk("call_nonempty", ras_empty, 1'b0);
    idle(); idle();
    chk("after_idle_pc", pc_o, 16'h0202);
    do_ret();
    chk("ret_pc", pc_o, 16'h0011);
    chk("ret_empty", ras_empty, 1'b1);

    // Five nested calls on a 4-deep stack: oldest (0x0012) is overwritten
    for (int k = 0; k < 5; k++) begin
      do_call(16'h1000 + 16'(k) * 16'h0100);
      chk("nest_full", ras_full, (k >= 3) ? 1'b1 : 1'b0);
      chk("nest_ovf", ras_ovf, (k == 4) ? 1'b1 : 1'b0);
    end
    for (int k = 4; k >= 1; k--) begin
      do_ret();
      chk("lifo_pc", pc_o, 16'h1000 + 16'(k - 1) * 16'h0100 + 16'h0001);
    end
    chk("drain_empty", ras_empty, 1'b1);
    do_ret();
    chk("unf_pc", pc_o, 16'h1002);
    chk("unf_flag", ras_unf, 1'b1);

    // Stall beats branch
    do_jmp(16'h0040);
    set_in(1, 1, 1, 16'h0100, 0, 0, 16'h0, 0);
    #1 chk("stall_next", pc_next_o, 16'h0040);
    tick();
    chk("stall_pc", pc_o, 16'h0040);
    set_in(1, 0, 1, 16'h0100, 0, 0, 16'h0, 0);
    #1 chk("br_next", pc_next_o, 16'h0100);
    tick();
    chk("br_pc", pc_o, 16'h0100);

    // Wrap and jmp-over-branch priority
    do_jmp(16'hFFFF);
    idle();
    chk("wrap_pc", pc_o, 16'h0000);
    set_in(1, 0, 1, 16'h0123, 1, 0, 16'h0ABC, 0);
    tick();
    chk("jmp_prio_pc", pc_o, 16'h0ABC);

    // call+ret together: ret only (stack currently empty -> sequential)
    set_in(1, 0, 0, 16'h0, 0, 1, 16'h0777, 1);
    tick();
    chk("callret_pc", pc_o, 16'h0ABD);
    chk("callret_empty", ras_empty, 1'b1);

    // Reset mid-sequence with call asserted discards the stack
    do_call(16'h0300);
    do_call(16'h0400);
    set_in(0, 0, 0, 16'h0, 0, 1, 16'h0500, 0);
    tick();
    chk("rst2_pc", pc_o, 16'h0000);
    chk("rst2_empty", ras_empty, 1'b1);
    chk("rst2_ovf", ras_ovf, 1'b0);
    chk("rst2_unf", ras_unf, 1'b0);
    chk("rst2_valid", valid_o, 1'b0);
    do_ret();
    chk("rst2_ret_pc", pc_o, 16'h0001);
    chk("rst2_ret_unf", ras_unf, 1'b1);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] bt, jt;
      bt = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      jt = ($urandom_range(0, 15) == 0) ? 16'hFFFE : 16'($urandom);
      set_in($urandom_range(0, 99) != 0,
             $urandom_range(0, 4) == 0,
             $urandom_range(0, 3) == 0, bt,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) == 0, jt,
             $urandom_range(0, 4) == 0);
      tick();
    end

    idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
